// File: rtl/dii_pkg.sv
// Shared types for the dii packet path: packetizer FSM states
// and header word positions within a packet.
package dii_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD
  } dii_state_e;

  localparam int HDR_DEST = 0;
  localparam int HDR_SRC  = 1;
  localparam int HDR_TYPE = 2;

  function automatic logic [15:0] hdr_word(
    input int          idx,
    input logic [15:0] dest,
    input logic [9:0]  id,
    input logic [15:0] typ
  );
    logic [15:0] w;
    w = typ;
    if (idx == HDR_DEST)
      w = dest;
    else if (idx == HDR_SRC)
      w = {6'b0, id};
    return w;
  endfunction

endpackage

// File: rtl/dii_channel.sv
// One dii link: 16-bit flit with last marker, valid/ready handshake.
interface dii_channel;

  logic [15:0] data;
  logic        last;
  logic        valid;
  logic        ready;

  modport master (
    output data,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  last,
    input  valid,
    output ready
  );

endinterface

// File: rtl/dii_packetizer.sv
// Builds DEST/SRC/TYPE header plus payload flits from a request
// and a payload stream; output flit is held in a register.
module dii_packetizer
  import dii_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  id,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_dest,
  input  logic [15:0] req_type,
  input  logic [3:0]  req_len,
  input  logic [15:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  dii_channel.master  out,
  output logic        err_len
);

  localparam logic [3:0] MAXL = 4'(MAX_LEN);

  dii_state_e  state_q, state_d;
  logic [15:0] type_q, type_d;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] data_q, data_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        alive_q;
  logic        hs;
  logic        pl_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
    end
  end

  // PAYLOAD is entered while TYPE is still on the wire so the
  // first payload word can follow it without a bubble.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    rem_d     = rem_q;
    data_d    = data_q;
    last_d    = last_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    hs        = valid_q && out.ready;
    req_ready = alive_q && (state_q == S_IDLE);
    pl_ready  = (state_q == S_PAYLOAD) && (rem_q != 4'd0)
                && (!valid_q || out.ready);
    pl_take   = pl_valid && pl_ready;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_len > MAXL) begin
            err_d = 1'b1;
          end else begin
            type_d  = req_type;
            rem_d   = req_len;
            data_d  = hdr_word(HDR_DEST, req_dest, id, req_type);
            last_d  = 1'b0;
            valid_d = 1'b1;
            state_d = S_DEST;
          end
        end
      end
      S_DEST: begin
        if (hs) begin
          data_d  = hdr_word(HDR_SRC, 16'h0, id, type_q);
          state_d = S_SRC;
        end
      end
      S_SRC: begin
        if (hs) begin
          data_d  = hdr_word(HDR_TYPE, 16'h0, id, type_q);
          last_d  = (rem_q == 4'd0);
          state_d = (rem_q == 4'd0) ? S_TYPE : S_PAYLOAD;
        end
      end
      S_TYPE: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (pl_take) begin
          data_d  = pl_data;
          last_d  = (rem_q == 4'd1);
          rem_d   = rem_q - 4'd1;
          valid_d = 1'b1;
        end else if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (rem_q == 4'd0)
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out.data  = data_q;
  assign out.last  = last_q;
  assign out.valid = valid_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_dii_packetizer.sv
// Directed bench for dii_packetizer: cycle table plus reset
// abort and back-to-back starvation sequences.
module tb_dii_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  id;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_dest;
  logic [15:0] req_type;
  logic [3:0]  req_len;
  logic [15:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        err_len;

  dii_channel ch ();

  dii_packetizer #(.MAX_LEN(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .id       (id),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dest (req_dest),
    .req_type (req_type),
    .req_len  (req_len),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .out      (ch),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    logic [15:0] dest;
    logic [15:0] typ;
    logic [3:0]  len;
    bit          pv;
    logic [15:0] pd;
    bit          rdy;
    logic [9:0]  id;
    bit          ev;
    logic [15:0] ed;
    bit          el;
    bit          er;
    bit          rr;
    bit          pr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  logic [15:0] fd[$];
  logic        fl[$];
  bit          mon_en = 1'b0;
  logic [14:0] vpat;
  int          vcnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(
    bit rv, logic [15:0] dest, logic [15:0] typ, logic [3:0] len,
    bit pv, logic [15:0] pd, bit rdy, logic [9:0] idv,
    bit ev, logic [15:0] ed, bit el, bit er, bit rr, bit pr);
    vec_t r;
    r.rv = rv; r.dest = dest; r.typ = typ; r.len = len;
    r.pv = pv; r.pd = pd; r.rdy = rdy; r.id = idv;
    r.ev = ev; r.ed = ed; r.el = el; r.er = er;
    r.rr = rr; r.pr = pr;
    return r;
  endfunction

  task automatic tick();
    #1;
    if (mon_en) begin
      if (ch.valid && ch.ready) begin
        fd.push_back(ch.data);
        fl.push_back(ch.last);
      end
      if (vcnt < 15) vpat[vcnt] = ch.valid;
      vcnt++;
    end
    @(negedge clk);
  endtask

  task automatic chk_flits(string nm, logic [15:0] ed[], bit el[]);
    chk({nm, ".count"}, fd.size(), ed.size());
    if (fd.size() == ed.size()) begin
      foreach (ed[k]) begin
        chk($sformatf("%s.d%0d", nm, k), fd[k], ed[k]);
        chk($sformatf("%s.l%0d", nm, k), fl[k], el[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; id = 10'h003;
    req_valid = 0; req_dest = 0; req_type = 0; req_len = 0;
    pl_data = 0; pl_valid = 0; ch.ready = 1'b1;

    // rv dest typ len pv pd rdy id | ev ed el er rr pr
    tbl.push_back(v(1,16'h0005,16'h2000,2,0,0,1,3, 0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 1,16'h0005,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 1,16'h0003,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,16'hAAAA,1,3, 1,16'h2000,0,0,0,1));
    tbl.push_back(v(0,0,0,0,1,16'hBBBB,1,3, 1,16'hAAAA,0,0,0,1));
    tbl.push_back(v(0,0,0,0,1,16'hCCCC,1,3, 1,16'hBBBB,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 0,0,0,0,1,0));
    tbl.push_back(v(1,16'h0777,16'h1234,0,1,16'h5555,1,3, 0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,1,16'h5555,1,3, 1,16'h0777,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,16'h5555,1,3, 1,16'h0003,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,16'h5555,1,3, 1,16'h1234,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 0,0,0,0,1,0));
    tbl.push_back(v(1,16'h00FF,16'h0,9,0,0,1,3, 0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 0,0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 0,0,0,0,1,0));
    tbl.push_back(v(1,16'h0042,16'h0100,1,0,0,1,3, 0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 1,16'h0042,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,3, 1,16'h0003,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,10'h155, 1,16'h0003,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,10'h155, 1,16'h0003,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,16'hDEAD,1,10'h155, 1,16'h0100,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 1,16'hDEAD,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,1,3, 0,0,0,0,1,0));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid", ch.valid, 0);
    chk("rst.last", ch.last, 0);
    chk("rst.data", ch.data, 0);
    chk("rst.err", err_len, 0);
    chk("rst.req_ready", req_ready, 0);
    chk("rst.pl_ready", pl_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rel.req_ready", req_ready, 1);
    @(negedge clk);

    foreach (tbl[i]) begin
      req_valid = tbl[i].rv; req_dest = tbl[i].dest;
      req_type = tbl[i].typ; req_len = tbl[i].len;
      pl_valid = tbl[i].pv; pl_data = tbl[i].pd;
      ch.ready = tbl[i].rdy; id = tbl[i].id;
      #1;
      chk($sformatf("v%0d.valid", i), ch.valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d.data", i), ch.data, tbl[i].ed);
        chk($sformatf("v%0d.last", i), ch.last, tbl[i].el);
      end
      chk($sformatf("v%0d.err", i), err_len, tbl[i].er);
      chk($sformatf("v%0d.req_ready", i), req_ready, tbl[i].rr);
      chk($sformatf("v%0d.pl_ready", i), pl_ready, tbl[i].pr);
      @(negedge clk);
    end
    req_valid = 0; pl_valid = 0; ch.ready = 1'b1; id = 10'h003;

    // reset in the middle of a len=4 packet
    req_valid = 1; req_dest = 16'h0A0A; req_type = 16'h0B0B;
    req_len = 4;
    tick();
    req_valid = 0;
    tick();
    tick();
    pl_valid = 1; pl_data = 16'h1111;
    tick();
    pl_data = 16'h2222;
    tick();
    pl_valid = 0;
    #1;
    chk("abort.pre_data", ch.data, 16'h2222);
    rst = 1'b0;
    #1;
    chk("abort.valid", ch.valid, 0);
    chk("abort.data", ch.data, 0);
    chk("abort.req_ready", req_ready, 0);
    chk("abort.pl_ready", pl_ready, 0);
    @(negedge clk);
    #1;
    chk("abort.valid2", ch.valid, 0);
    @(negedge clk);
    rst = 1'b1;
    fd.delete(); fl.delete(); vcnt = 0; mon_en = 1'b1;
    tick();
    req_valid = 1; req_dest = 16'h0C0C; req_type = 16'h0D0D;
    req_len = 1; pl_valid = 1; pl_data = 16'h3333;
    tick();
    req_valid = 0;
    repeat (10) tick();
    mon_en = 1'b0; pl_valid = 0;
    chk_flits("abort",
      '{16'h0C0C, 16'h0003, 16'h0D0D, 16'h3333},
      '{1'b0, 1'b0, 1'b0, 1'b1});

    // back-to-back len=1 packets with starved payload
    fd.delete(); fl.delete(); vcnt = 0; vpat = '0; mon_en = 1'b1;
    for (int c = 0; c < 15; c++) begin
      req_valid = (c == 0) || (c == 6) || (c == 7);
      req_dest = (c == 0) ? 16'h0011 : 16'h0044;
      req_type = (c == 0) ? 16'h0022 : 16'h0055;
      req_len = 1;
      pl_valid = (c == 5) || (c == 12);
      pl_data = (c == 5) ? 16'h0033 : 16'h0066;
      tick();
    end
    mon_en = 1'b0; req_valid = 0; pl_valid = 0;
    chk("b2b.valid_pattern", vpat, 15'b010011101001110);
    chk_flits("b2b",
      '{16'h0011, 16'h0003, 16'h0022, 16'h0033,
        16'h0044, 16'h0003, 16'h0055, 16'h0066},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
